flags_save_stack: RTL
=====================

Name: flags_save_stack

Overview:
- LIFO save/restore store for the 4-bit condition-code register across interrupt entry and return.
- On interrupt entry, `push` captures the current CCR value. On return-from-interrupt, `pop` pops the top entry and drives a one-cycle restore pulse and value straight into the flags register's restore inputs.
- Nested interrupts are supported up to DEPTH levels, with overflow/underflow detection.

Parameters:
- DEPTH, 4, number of saved CCR entries (nesting depth), >= 2.
- FLAGS_W, 4, CCR width; bit order Z=0, N=1, C=2, V=3.
- CNT_W, $clog2(DEPTH+1), width of occupancy count (derived, not overridden).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- push  in  1  interrupt entry: save CCR this cycle.
- flags_in  in  FLAGS_W  current CCR value from the flags register.
- pop  in  1  return-from-interrupt: restore most recent save.
- clr_err  in  1  clears sticky error flags.
- restore_flags  out  1  one-cycle restore strobe to the flags register.
- restore_flags_value  out  FLAGS_W  value to load into CCR; valid while restore_flags is high.
- count  out  CNT_W  number of valid entries, 0..DEPTH.
- empty  out  1  count==0 (combinational from count).
- full  out  1  count==DEPTH (combinational from count).
- overflow_err  out  1  sticky: push dropped while full.
- underflow_err  out  1  sticky: pop while empty.

Behaviour:
- Reset: entries cleared to 0, count=0, restore_flags=0, restore_flags_value=0, overflow_err=0, underflow_err=0. Reset during a pending restore aborts it; no pulse is produced.
- Storage: register array indexed by count. Top entry is entry[count-1]. No wrap-around; the pointer saturates at 0 and DEPTH.
- Save source (push_data):
  - push_data = restore_flags_value if restore_flags is high this cycle, else flags_in.
  - Rationale: the flags register gives restore priority on the same edge, so a push coincident with a restore pulse must save the restored value, not the stale CCR.
- Pop latency:
  - pop sampled at edge N drives restore_flags=1 for exactly the cycle after edge N, with restore_flags_value = the popped entry.
  - CCR therefore updates at edge N+1.
  - restore_flags_value holds its last value when restore_flags=0.
- Cases at each edge, evaluated on the pre-edge count:
  - push only, not full: entry[count] <= push_data, count+1.
  - push only, full: drop; count and storage unchanged; overflow_err <= 1.
  - pop only, not empty: restore pulse with entry[count-1]; count-1.
  - pop only, empty: no restore pulse; underflow_err <= 1; restore_flags_value unchanged.
  - push and pop, not empty: restore pulse with old top entry[count-1]; entry[count-1] <= push_data; count unchanged. This applies when full as well; no overflow.
  - push and pop, empty: pass-through; restore pulse with push_data; count stays 0; no error.
  - neither: hold; restore_flags <= 0.
- Back-to-back pops are allowed every cycle; each produces its own pulse.
- Errors: clr_err clears both sticky flags. If an error event occurs in the same cycle as clr_err, set wins. Error flags have no effect on stack operation.
- Fully synchronous apart from rst; no combinational path from inputs to restore_flags or restore_flags_value.

Decomposition:
- Shared package (cpu_pkg):
  - FLAGS_W
  - flag bit index constants FLAG_Z=0, FLAG_N=1, FLAG_C=2, FLAG_V=3
  - default stack DEPTH constant
- No sub-module; storage array, counter and restore register form one module. Size the array from DEPTH.

Test Plan:
- Reset then idle -> count=0, empty=1, full=0, restore_flags=0, restore_flags_value=0, both errors 0.
- Push 4'h1, 4'h2, 4'h3 on consecutive cycles, then pop x3 -> restore pulses in consecutive cycles with values 3, 2, 1, each one cycle after its pop; count 3->0; empty=1 at end.
- DEPTH=4: push 5 values A,B,C,D,E -> full=1 after D, E dropped, overflow_err=1, count=4. Pop -> restore value D. clr_err -> overflow_err=0.
- Pop while empty -> no restore pulse, underflow_err=1. Pop plus clr_err with stack still empty -> underflow_err stays 1.
- Stack holds {5}; push 4'h9 plus pop in the same cycle -> restore 5 next cycle, count=1. Following pop -> restore 9.
- Pop {7} at edge N, push at edge N+1 with flags_in=4'hF -> saved entry is 7 (forwarded restore value). A later pop restores 7.
- Empty stack; push 4'hA plus pop -> restore pulse with A, count=0, no error flags.

Source files
------------

// File: rtl/flags_save_stack_pkg.sv
// Shared CPU definitions for the condition-code register and its
// interrupt save stack.
package flags_save_stack_pkg;
   localparam int FLAGS_W       = 4;
   localparam int FLAG_Z        = 0;
   localparam int FLAG_N        = 1;
   localparam int FLAG_C        = 2;
   localparam int FLAG_V        = 3;
   localparam int DEFAULT_DEPTH = 4;
endpackage

// File: rtl/flags_save_stack_if.sv
// Bundle between the interrupt sequencer / flags register (master) and the
// CCR save stack (slave).
interface flags_save_stack_if
   #(parameter int DEPTH = flags_save_stack_pkg::DEFAULT_DEPTH,
     parameter int CNT_W = $clog2(DEPTH + 1));
   import flags_save_stack_pkg::*;

   logic               push;
   logic [FLAGS_W-1:0] flags_in;
   logic               pop;
   logic               clr_err;
   logic               restore_flags;
   logic [FLAGS_W-1:0] restore_flags_value;
   logic [CNT_W-1:0]   count;
   logic               empty;
   logic               full;
   logic               overflow_err;
   logic               underflow_err;

   modport master (
      output push, flags_in, pop, clr_err,
      input  restore_flags, restore_flags_value, count, empty, full,
             overflow_err, underflow_err
   );

   modport slave (
      input  push, flags_in, pop, clr_err,
      output restore_flags, restore_flags_value, count, empty, full,
             overflow_err, underflow_err
   );
endinterface

// File: rtl/flags_save_stack.sv
// LIFO of condition-code values saved on interrupt entry and restored on
// return, with a registered one-cycle restore strobe and sticky error flags.
module flags_save_stack
   import flags_save_stack_pkg::*;
   #(parameter int DEPTH = DEFAULT_DEPTH,
     parameter int CNT_W = $clog2(DEPTH + 1))
   (
      input logic              clk,
      input logic              rst,
      flags_save_stack_if.slave bus
   );

   localparam int IDX_W = $clog2(DEPTH);

   logic [FLAGS_W-1:0] entries_r [DEPTH];
   logic [CNT_W-1:0]   count_r;
   logic               restore_r;
   logic [FLAGS_W-1:0] value_r;
   logic               ovf_r;
   logic               unf_r;

   logic               empty_s;
   logic               full_s;
   logic [IDX_W-1:0]   top_idx_s;
   logic [FLAGS_W-1:0] push_data_s;
   logic [CNT_W-1:0]   count_n_s;
   logic               restore_n_s;
   logic [FLAGS_W-1:0] value_n_s;
   logic               wr_en_s;
   logic [IDX_W-1:0]   wr_idx_s;
   logic               ovf_set_s;
   logic               unf_set_s;

   assign empty_s = (count_r == {CNT_W{1'b0}});
   assign full_s  = (count_r == CNT_W'(DEPTH));

   // Next-state decode of the push/pop combinations against the pre-edge count.
   always_comb begin
      count_n_s   = count_r;
      restore_n_s = 1'b0;
      value_n_s   = value_r;
      wr_en_s     = 1'b0;
      wr_idx_s    = {IDX_W{1'b0}};
      ovf_set_s   = 1'b0;
      unf_set_s   = 1'b0;
      // The flags register takes a restore on the same edge as a save, so
      // forward the value being restored rather than the stale CCR.
      if (restore_r) begin
         push_data_s = value_r;
      end else begin
         push_data_s = bus.flags_in;
      end
      if (empty_s) begin
         top_idx_s = {IDX_W{1'b0}};
      end else begin
         top_idx_s = IDX_W'(count_r - CNT_W'(1));
      end

      case ({bus.push, bus.pop})
         2'b10: begin
            if (full_s) begin
               ovf_set_s = 1'b1;
            end else begin
               wr_en_s   = 1'b1;
               wr_idx_s  = IDX_W'(count_r);
               count_n_s = count_r + CNT_W'(1);
            end
         end
         2'b01: begin
            if (empty_s) begin
               unf_set_s = 1'b1;
            end else begin
               restore_n_s = 1'b1;
               value_n_s   = entries_r[top_idx_s];
               count_n_s   = count_r - CNT_W'(1);
            end
         end
         2'b11: begin
            restore_n_s = 1'b1;
            if (empty_s) begin
               value_n_s = push_data_s;
            end else begin
               value_n_s = entries_r[top_idx_s];
               wr_en_s   = 1'b1;
               wr_idx_s  = top_idx_s;
            end
         end
         default: begin
            restore_n_s = 1'b0;
         end
      endcase
   end

   // State registers: storage, occupancy, restore strobe/value and sticky errors.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            entries_r[i] <= {FLAGS_W{1'b0}};
         end
         count_r   <= {CNT_W{1'b0}};
         restore_r <= 1'b0;
         value_r   <= {FLAGS_W{1'b0}};
         ovf_r     <= 1'b0;
         unf_r     <= 1'b0;
      end else begin
         if (wr_en_s) begin
            entries_r[wr_idx_s] <= push_data_s;
         end
         count_r   <= count_n_s;
         restore_r <= restore_n_s;
         value_r   <= value_n_s;
         ovf_r     <= ovf_set_s | (ovf_r & ~bus.clr_err);
         unf_r     <= unf_set_s | (unf_r & ~bus.clr_err);
      end
   end

   assign bus.restore_flags       = restore_r;
   assign bus.restore_flags_value = value_r;
   assign bus.count               = count_r;
   assign bus.empty               = empty_s;
   assign bus.full                = full_s;
   assign bus.overflow_err        = ovf_r;
   assign bus.underflow_err       = unf_r;

endmodule
